regfile_mp: RTL and testbench

Parametrised multi-read-port register file, the next generation of the core's 2R/1W integer register file. It adds configurable width, depth and read-port count, per-byte write strobes, optional write-to-read bypass and a hardwired zero register. Reset starts a one-entry-per-cycle clear sweep, so the array can map to RAM. It sits between decode (read addresses) and writeback (write port) in the datapath.

---
 rtl/regfile_mp.sv | 109 ++++++++++
 tb/tb_regfile_mp.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-read-port register file with byte strobes, optional write bypass and zero register.
// Read latency 1 cycle; a reset starts a DEPTH-cycle clear sweep (one entry per enabled cycle).
// No backpressure: requests are ignored while busy, and en=0 freezes every piece of state.
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       en,
   input  logic [NUM_RD-1:0]          rd_en,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_valid,
   input  logic                       we,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic [DATA_W/8-1:0]        wr_strb,
   output logic                       busy
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int NB    = DATA_W / 8;

   typedef enum logic {S_INIT, S_READY} state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   idx, idx_nxt;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DATA_W-1:0]   wmask;
   logic                wr_ok;
   logic [DATA_W-1:0]   rd_val [NUM_RD];

   // State and sweep index register; reset restarts the clear sweep from entry 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_INIT;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // Sweep advances one entry per enabled cycle; completion is detected on the last index, not on wrap.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      if (en && state == S_INIT) begin
         idx_nxt = idx + 1'b1;
         if (idx == ADDR_W'(DEPTH - 1))
            state_nxt = S_READY;
      end
   end

   assign busy = (state == S_INIT);

   // Expand byte strobes into a bit mask shared by the array write and the bypass merge.
   always_comb begin
      wmask = '0;
      for (int b = 0; b < NB; b++)
         wmask[8*b +: 8] = {8{wr_strb[b]}};
   end

   assign wr_ok = en && (state == S_READY) && we && !((ZERO_REG != 0) && (wr_addr == '0));

   // Array write port: clears during the sweep, strobed merge in normal operation. No reset on storage.
   always_ff @(posedge clk) begin
      if (!reset && en) begin
         if (state == S_INIT)
            mem[idx] <= '0;
         else if (wr_ok)
            mem[wr_addr] <= (mem[wr_addr] & ~wmask) | (wr_data & wmask);
      end
   end

   // Per-port read value: old entry, optionally merged with a same-cycle write, forced to 0 for entry 0.
   always_comb begin
      for (int i = 0; i < NUM_RD; i++) begin
         rd_val[i] = mem[rd_addr[i*ADDR_W +: ADDR_W]];
         if ((BYPASS != 0) && we && (wr_addr == rd_addr[i*ADDR_W +: ADDR_W]))
            rd_val[i] = (rd_val[i] & ~wmask) | (wr_data & wmask);
         if ((ZERO_REG != 0) && (rd_addr[i*ADDR_W +: ADDR_W] == '0))
            rd_val[i] = '0;
      end
   end

   // Registered read outputs; data holds on ports that are not reading, valid follows rd_en.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data  <= '0;
         rd_valid <= '0;
      end else if (en) begin
         if (state == S_READY) begin
            for (int i = 0; i < NUM_RD; i++) begin
               rd_valid[i] <= rd_en[i];
               if (rd_en[i])
                  rd_data[i*DATA_W +: DATA_W] <= rd_val[i];
            end
         end else begin
            rd_valid <= '0;
         end
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a bypass instance and a non-bypass instance share stimulus.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
// Directed vector table for single-cycle behaviour plus hand sequences for sweep/reset/hold cases.
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        reset, en, we;
   logic [1:0]  rd_en;
   logic [9:0]  rd_addr;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;
   logic [63:0] rd_data_a, rd_data_b;
   logic [1:0]  rd_valid_a, rd_valid_b;
   logic        busy_a, busy_b;

   int checks   = 0;
   int failures = 0;
   int cnt;

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [3:0]  ws;
      logic [1:0]  re;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [1:0]  ev;
      logic [31:0] ea0, ea1, eb0, eb1;
   } vec_t;

   vec_t vt [10];

   regfile_mp dut_a (
      .clk(clk), .reset(reset), .en(en), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data_a), .rd_valid(rd_valid_a), .we(we), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_strb(wr_strb), .busy(busy_a)
   );

   regfile_mp #(.BYPASS(0)) dut_b (
      .clk(clk), .reset(reset), .en(en), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data_b), .rd_valid(rd_valid_b), .we(we), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_strb(wr_strb), .busy(busy_b)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic rd2(input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1);
      rd_en   = re;
      rd_addr = {a1, a0};
   endtask

   initial begin
      reset = 1'b1; en = 1'b1; we = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
      rd2(2'b00, 5'd0, 5'd0);

      //              we    wa     wd            ws     re     ra0    ra1    ev     ea0           ea1           eb0           eb1
      vt[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 2'b00, 5'd0, 5'd0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0};
      vt[1] = '{1'b0, 5'd0, 32'h0,        4'h0, 2'b11, 5'd5, 5'd5, 2'b11, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
      vt[2] = '{1'b1, 5'd7, 32'h11223344, 4'hF, 2'b00, 5'd0, 5'd0, 2'b00, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
      vt[3] = '{1'b1, 5'd7, 32'hAABBCCDD, 4'h5, 2'b01, 5'd7, 5'd5, 2'b01, 32'h11BB33DD, 32'hDEADBEEF, 32'h11223344, 32'hDEADBEEF};
      vt[4] = '{1'b0, 5'd0, 32'h0,        4'h0, 2'b11, 5'd7, 5'd7, 2'b11, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD};
      vt[5] = '{1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 2'b11, 5'd0, 5'd5, 2'b11, 32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
      vt[6] = '{1'b0, 5'd0, 32'h0,        4'h0, 2'b11, 5'd7, 5'd0, 2'b11, 32'h11BB33DD, 32'h0,        32'h11BB33DD, 32'h0};
      vt[7] = '{1'b1, 5'd5, 32'h0,        4'h0, 2'b01, 5'd5, 5'd0, 2'b01, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
      vt[8] = '{1'b1, 5'd5, 32'h55000000, 4'h8, 2'b11, 5'd7, 5'd5, 2'b11, 32'h11BB33DD, 32'h55ADBEEF, 32'h11BB33DD, 32'hDEADBEEF};
      vt[9] = '{1'b0, 5'd0, 32'h0,        4'h0, 2'b01, 5'd5, 5'd0, 2'b01, 32'h55ADBEEF, 32'h55ADBEEF, 32'h55ADBEEF, 32'hDEADBEEF};

      // Reset state
      step;
      chk("rst_busy",  {busy_a, busy_b}, 2'b11);
      chk("rst_valid", {rd_valid_a, rd_valid_b}, 4'b0000);
      chk("rst_data_a", rd_data_a, 64'h0);
      chk("rst_data_b", rd_data_b, 64'h0);
      reset = 1'b0;

      // Sweep length with en held high
      cnt = 0;
      for (int i = 0; i < 100 && busy_a; i++) begin
         step;
         cnt++;
      end
      chk("sweep_len", cnt, 32);
      chk("sweep_done_b", busy_b, 1'b0);

      // Every entry reads back 0 on both ports
      for (int a = 0; a < 32; a++) begin
         rd2(2'b11, 5'(a), 5'(31 - a));
         step;
         chk("clr_valid", rd_valid_a, 2'b11);
         chk("clr_data_a", rd_data_a, 64'h0);
         chk("clr_data_b", rd_data_b, 64'h0);
      end
      rd2(2'b00, 5'd0, 5'd0);
      step;
      chk("valid_drop", {rd_valid_a, rd_valid_b}, 4'b0000);

      // Directed vectors
      for (int v = 0; v < 10; v++) begin
         we = vt[v].we; wr_addr = vt[v].wa; wr_data = vt[v].wd; wr_strb = vt[v].ws;
         rd2(vt[v].re, vt[v].ra0, vt[v].ra1);
         step;
         chk($sformatf("vec%0d_valid", v), {rd_valid_a, rd_valid_b}, {vt[v].ev, vt[v].ev});
         chk($sformatf("vec%0d_data_a", v), rd_data_a, {vt[v].ea1, vt[v].ea0});
         chk($sformatf("vec%0d_data_b", v), rd_data_b, {vt[v].eb1, vt[v].eb0});
      end

      // Hold with en=0: outputs frozen, write to addr 3 dropped
      en = 1'b0; we = 1'b1; wr_addr = 5'd3; wr_data = 32'h12345678; wr_strb = 4'hF;
      rd2(2'b11, 5'd3, 5'd3);
      step;
      chk("hold_valid", {rd_valid_a, rd_valid_b}, 4'b0101);
      chk("hold_data_a", rd_data_a, {32'h55ADBEEF, 32'h55ADBEEF});
      chk("hold_data_b", rd_data_b, {32'hDEADBEEF, 32'h55ADBEEF});
      en = 1'b1; we = 1'b0;
      step;
      chk("hold_addr3", rd_data_a, 64'h0);
      chk("hold_addr3_valid", rd_valid_a, 2'b11);

      // Write addr 9, then reset partway through the sweep
      we = 1'b1; wr_addr = 5'd9; wr_data = 32'h00001234; wr_strb = 4'hF;
      rd2(2'b00, 5'd0, 5'd0);
      step;
      we = 1'b0;
      rd2(2'b01, 5'd9, 5'd0);
      step;
      chk("pre_rst_addr9", rd_data_a[31:0], 32'h00001234);
      reset = 1'b1;
      step;
      reset = 1'b0;
      chk("rst2_out", {busy_a, rd_valid_a, rd_data_a}, {1'b1, 2'b00, 64'h0});
      we = 1'b1; wr_addr = 5'd11; wr_data = 32'hFFFFFFFF; wr_strb = 4'hF;
      rd2(2'b11, 5'd11, 5'd9);
      for (int i = 0; i < 10; i++) begin
         step;
         chk("init_no_valid", {busy_a, rd_valid_a}, 3'b100);
      end
      reset = 1'b1;
      step;
      reset = 1'b0;

      // Restarted sweep with en toggling; writes to addr 12 issued throughout must be dropped
      wr_addr = 5'd12;
      cnt = 0;
      for (int i = 0; i < 200 && busy_a; i++) begin
         en = (i % 4 != 3);
         step;
         if (en) cnt++;
         else chk("sweep_en0_busy", busy_a, 1'b1);
      end
      chk("sweep2_len", cnt, 32);
      chk("sweep2_done_b", busy_b, 1'b0);
      en = 1'b1; we = 1'b0;

      rd2(2'b11, 5'd9, 5'd11);
      step;
      chk("post_rst_9_11_a", {rd_valid_a, rd_data_a}, {2'b11, 64'h0});
      chk("post_rst_9_11_b", {rd_valid_b, rd_data_b}, {2'b11, 64'h0});
      rd2(2'b11, 5'd12, 5'd5);
      step;
      chk("post_rst_12_5", {rd_valid_a, rd_data_a}, {2'b11, 64'h0});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
